booth_areg: RTL and testbench

BOOTH_AREG -- requirements
Module: booth_areg

---
 rtl/booth_areg.sv | 136 +++++++++++++
 tb/tb_booth_areg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_areg.sv
// Booth multiplier accumulator register: load/clear, arithmetic and serial
// right shifts with a pass counter, and add/subtract with sticky overflow.
module booth_areg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEPS = WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [WIDTH-1:0]               in,
   input  logic [WIDTH-1:0]               m,
   input  logic [2:0]                     ctrl,
   input  logic                           ser_in,
   output logic [WIDTH-1:0]               o,
   output logic                           shiftBit,
   output logic [$clog2(STEPS+1)-1:0]     cnt,
   output logic                           done,
   output logic                           ovf
);

   localparam int unsigned CW  = $clog2(STEPS + 1);
   localparam int unsigned MSB = WIDTH - 1;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_CLEAR = 3'b001,
      OP_ASHR  = 3'b010,
      OP_HOLD  = 3'b011,
      OP_ADD   = 3'b100,
      OP_SUB   = 3'b101,
      OP_SHR   = 3'b110,
      OP_HOLD2 = 3'b111
   } op_t;

   generate
      if (WIDTH < 2 || WIDTH > 64 || STEPS < 1 || STEPS > WIDTH) begin : g_bad_param
         $error("booth_areg: illegal WIDTH/STEPS");
      end
   endgenerate

   op_t              op;
   logic [WIDTH-1:0] areg_q, areg_nxt;
   logic             sb_q, sb_nxt;
   logic [CW-1:0]    cnt_q, cnt_nxt;
   logic             ovf_q, ovf_nxt;
   logic [WIDTH-1:0] sum, diff;
   logic             add_ovf, sub_ovf;
   logic             done_c;

   assign op      = op_t'(ctrl);
   assign done_c  = (cnt_q == CW'(STEPS));
   assign sum     = areg_q + m;
   assign diff    = areg_q - m;
   // Signed overflow: result sign departs from the accumulator sign when
   // operands effectively share a sign.
   assign add_ovf = (areg_q[MSB] == m[MSB]) && (sum[MSB]  != areg_q[MSB]);
   assign sub_ovf = (areg_q[MSB] != m[MSB]) && (diff[MSB] != areg_q[MSB]);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         areg_q <= '0;
         sb_q   <= 1'b0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         areg_q <= areg_nxt;
         sb_q   <= sb_nxt;
         cnt_q  <= cnt_nxt;
         ovf_q  <= ovf_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      areg_nxt = areg_q;
      sb_nxt   = areg_q[0];
      cnt_nxt  = cnt_q;
      ovf_nxt  = ovf_q;
      case (op)
         OP_LOAD: begin
            areg_nxt = in;
            sb_nxt   = in[0];
            cnt_nxt  = '0;
            ovf_nxt  = 1'b0;
         end
         OP_CLEAR: begin
            areg_nxt = '0;
            sb_nxt   = 1'b0;
            cnt_nxt  = '0;
            ovf_nxt  = 1'b0;
         end
         OP_ASHR: begin
            // A finished pass freezes shifts, including the shifted-out bit.
            if (done_c) begin
               sb_nxt = sb_q;
            end else begin
               areg_nxt = {areg_q[MSB], areg_q[MSB:1]};
               sb_nxt   = areg_q[0];
               cnt_nxt  = cnt_q + CW'(1);
            end
         end
         OP_SHR: begin
            if (done_c) begin
               sb_nxt = sb_q;
            end else begin
               areg_nxt = {ser_in, areg_q[MSB:1]};
               sb_nxt   = areg_q[0];
               cnt_nxt  = cnt_q + CW'(1);
            end
         end
         OP_ADD: begin
            areg_nxt = sum;
            sb_nxt   = sum[0];
            ovf_nxt  = ovf_q | add_ovf;
         end
         OP_SUB: begin
            areg_nxt = diff;
            sb_nxt   = diff[0];
            ovf_nxt  = ovf_q | sub_ovf;
         end
         OP_HOLD, OP_HOLD2: begin
            sb_nxt = areg_q[0];
         end
         default: begin
            sb_nxt = areg_q[0];
         end
      endcase
   end

   assign o        = areg_q;
   assign shiftBit = sb_q;
   assign cnt      = cnt_q;
   assign ovf      = ovf_q;
   assign done     = done_c;

endmodule

// File: tb/tb_booth_areg.sv
// Self-checking bench for booth_areg (WIDTH=8, STEPS=8): directed scenarios
// plus randomized operations against an arithmetic reference model.
module tb_booth_areg;

   logic       clk;
   logic       rst_n;
   logic [7:0] in;
   logic [7:0] m;
   logic [2:0] ctrl;
   logic       ser_in;
   logic [7:0] o;
   logic       shiftBit;
   logic [3:0] cnt;
   logic       done;
   logic       ovf;

   int checks;
   int errors;

   // Reference model state
   logic [7:0] mreg;
   logic       msb;
   int         mcnt;
   logic       movf;

   booth_areg #(.WIDTH(8), .STEPS(8)) dut (
      .clk(clk), .rst_n(rst_n), .in(in), .m(m), .ctrl(ctrl), .ser_in(ser_in),
      .o(o), .shiftBit(shiftBit), .cnt(cnt), .done(done), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int to_s(input logic [7:0] v);
      return (int'(v) > 127) ? int'(v) - 256 : int'(v);
   endfunction

   function automatic void model_reset();
      mreg = 8'h00; msb = 1'b0; mcnt = 0; movf = 1'b0;
   endfunction

   function automatic void model_step(input logic [2:0] c, input logic [7:0] d,
                                      input logic [7:0] mm, input logic s);
      int sa;
      int r;
      bit fin;
      fin = (mcnt == 8);
      case (c)
         3'd0: begin mreg = d; msb = d[0]; mcnt = 0; movf = 1'b0; end
         3'd1: begin mreg = 8'h00; msb = 1'b0; mcnt = 0; movf = 1'b0; end
         3'd2: if (!fin) begin
            msb = mreg[0];
            sa  = to_s(mreg);
            r   = (sa >= 0) ? sa / 2 : -((1 - sa) / 2);
            mreg = 8'(r);
            mcnt++;
         end
         3'd6: if (!fin) begin
            msb  = mreg[0];
            mreg = 8'(int'(mreg) / 2 + (s ? 128 : 0));
            mcnt++;
         end
         3'd4, 3'd5: begin
            r = (c == 3'd4) ? to_s(mreg) + to_s(mm) : to_s(mreg) - to_s(mm);
            if (r > 127 || r < -128) movf = 1'b1;
            mreg = 8'(r);
            msb  = mreg[0];
         end
         default: msb = mreg[0];
      endcase
   endfunction

   // Apply one operation across a rising edge and advance the model.
   task automatic do_op(input logic [2:0] c, input logic [7:0] d,
                        input logic [7:0] mm, input logic s);
      @(negedge clk);
      ctrl = c; in = d; m = mm; ser_in = s;
      @(posedge clk);
      #1;
      model_step(c, d, mm, s);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ctrl = 3'd3; in = 8'h00; m = 8'h00; ser_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      do_op(3'd0, 8'h5B, 8'h00, 1'b0);
      do_op(3'd2, 8'h00, 8'h00, 1'b0);
      checks++; if (o !== 8'h2D) begin errors++; $display("FAIL pre_reset_o: got %h want 2d", o); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if ({o, shiftBit, cnt, done, ovf} !== 16'h0000) begin
         errors++; $display("FAIL reset_async: got o=%h sb=%b cnt=%0d done=%b ovf=%b want all 0", o, shiftBit, cnt, done, ovf);
      end
      ctrl = 3'd0; in = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({o, shiftBit, cnt, done, ovf} !== 16'h0000) begin
         errors++; $display("FAIL reset_hold: got o=%h sb=%b cnt=%0d done=%b ovf=%b want all 0", o, shiftBit, cnt, done, ovf);
      end
      @(negedge clk); rst_n = 1'b1; ctrl = 3'd3;
   endtask

   task automatic test_ashr();
      do_op(3'd0, 8'hB4, 8'h00, 1'b0);
      do_op(3'd2, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, shiftBit, cnt} !== {8'hDA, 1'b0, 4'd1}) begin
         errors++; $display("FAIL ashr1: got o=%h sb=%b cnt=%0d want da/0/1", o, shiftBit, cnt);
      end
      do_op(3'd2, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, shiftBit, cnt} !== {8'hED, 1'b0, 4'd2}) begin
         errors++; $display("FAIL ashr2: got o=%h sb=%b cnt=%0d want ed/0/2", o, shiftBit, cnt);
      end
   endtask

   task automatic test_add_sub_ovf();
      do_op(3'd0, 8'h70, 8'h00, 1'b0);
      do_op(3'd4, 8'h00, 8'h20, 1'b0);
      checks++; if ({o, ovf, shiftBit} !== {8'h90, 1'b1, 1'b0}) begin
         errors++; $display("FAIL add_ovf: got o=%h ovf=%b sb=%b want 90/1/0", o, ovf, shiftBit);
      end
      do_op(3'd5, 8'h00, 8'h10, 1'b0);
      checks++; if ({o, ovf} !== {8'h80, 1'b1}) begin
         errors++; $display("FAIL sub_sticky: got o=%h ovf=%b want 80/1", o, ovf);
      end
      do_op(3'd3, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, ovf, shiftBit} !== {8'h80, 1'b1, 1'b0}) begin
         errors++; $display("FAIL hold_keep: got o=%h ovf=%b sb=%b want 80/1/0", o, ovf, shiftBit);
      end
      do_op(3'd0, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, ovf} !== {8'h00, 1'b0}) begin
         errors++; $display("FAIL load_clr_ovf: got o=%h ovf=%b want 00/0", o, ovf);
      end
      do_op(3'd0, 8'h80, 8'h00, 1'b0);
      do_op(3'd5, 8'h00, 8'h01, 1'b0);
      checks++; if ({o, ovf, shiftBit} !== {8'h7F, 1'b1, 1'b1}) begin
         errors++; $display("FAIL sub_ovf: got o=%h ovf=%b sb=%b want 7f/1/1", o, ovf, shiftBit);
      end
      do_op(3'd1, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, ovf, cnt} !== {8'h00, 1'b0, 4'd0}) begin
         errors++; $display("FAIL clear: got o=%h ovf=%b cnt=%0d want 00/0/0", o, ovf, cnt);
      end
   endtask

   task automatic test_shr();
      do_op(3'd0, 8'h01, 8'h00, 1'b0);
      do_op(3'd6, 8'h00, 8'h00, 1'b1);
      checks++; if ({o, shiftBit, cnt} !== {8'h80, 1'b1, 4'd1}) begin
         errors++; $display("FAIL shr: got o=%h sb=%b cnt=%0d want 80/1/1", o, shiftBit, cnt);
      end
      do_op(3'd6, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, shiftBit, cnt} !== {8'h40, 1'b0, 4'd2}) begin
         errors++; $display("FAIL shr0: got o=%h sb=%b cnt=%0d want 40/0/2", o, shiftBit, cnt);
      end
   endtask

   task automatic test_saturation();
      logic sb_prev;
      do_op(3'd0, 8'h80, 8'h00, 1'b0);
      for (int i = 0; i < 7; i++) begin
         do_op(3'd2, 8'h00, 8'h00, 1'b0);
         checks++; if (done !== 1'b0) begin
            errors++; $display("FAIL early_done: shift %0d got done=%b want 0", i + 1, done);
         end
      end
      do_op(3'd2, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, cnt, done} !== {8'hFF, 4'd8, 1'b1}) begin
         errors++; $display("FAIL pass_done: got o=%h cnt=%0d done=%b want ff/8/1", o, cnt, done);
      end
      sb_prev = shiftBit;
      do_op(3'd2, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, cnt, done, shiftBit} !== {8'hFF, 4'd8, 1'b1, sb_prev}) begin
         errors++; $display("FAIL sat_ashr: got o=%h cnt=%0d done=%b sb=%b want ff/8/1/%b", o, cnt, done, shiftBit, sb_prev);
      end
      do_op(3'd6, 8'h00, 8'h00, 1'b0);
      checks++; if ({o, cnt, shiftBit} !== {8'hFF, 4'd8, sb_prev}) begin
         errors++; $display("FAIL sat_shr: got o=%h cnt=%0d sb=%b want ff/8/%b", o, cnt, shiftBit, sb_prev);
      end
      do_op(3'd4, 8'h00, 8'h01, 1'b0);
      checks++; if ({o, cnt, done, ovf} !== {8'h00, 4'd8, 1'b1, 1'b0}) begin
         errors++; $display("FAIL sat_add: got o=%h cnt=%0d done=%b ovf=%b want 00/8/1/0", o, cnt, done, ovf);
      end
   endtask

   task automatic test_mid_reset();
      do_op(3'd0, 8'hA5, 8'h00, 1'b0);
      repeat (5) do_op(3'd2, 8'h00, 8'h00, 1'b0);
      checks++; if (cnt !== 4'd5) begin errors++; $display("FAIL mid_cnt: got %0d want 5", cnt); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if ({o, cnt, done, ovf, shiftBit} !== 16'h0000) begin
         errors++; $display("FAIL mid_reset: got o=%h cnt=%0d done=%b ovf=%b sb=%b want all 0", o, cnt, done, ovf, shiftBit);
      end
      @(negedge clk); rst_n = 1'b1;
      do_op(3'd0, 8'h3C, 8'h00, 1'b0);
      checks++; if ({o, cnt, shiftBit} !== {8'h3C, 4'd0, 1'b0}) begin
         errors++; $display("FAIL post_reset_load: got o=%h cnt=%0d sb=%b want 3c/0/0", o, cnt, shiftBit);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] c;
      int sel;
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 15));
         if (sel < 5)       c = 3'd2;
         else if (sel < 8)  c = 3'd6;
         else if (sel < 10) c = 3'd4;
         else if (sel < 12) c = 3'd5;
         else if (sel < 13) c = 3'd0;
         else if (sel < 14) c = 3'd1;
         else               c = (sel == 14) ? 3'd3 : 3'd7;
         do_op(c, 8'($urandom), 8'($urandom), 1'($urandom));
         checks++;
         if (o !== mreg || shiftBit !== msb || int'(cnt) !== mcnt ||
             done !== (mcnt == 8) || ovf !== movf) begin
            errors++;
            $display("FAIL rand[%0d] ctrl=%0d: got o=%h sb=%b cnt=%0d done=%b ovf=%b want o=%h sb=%b cnt=%0d done=%b ovf=%b",
                     n, c, o, shiftBit, cnt, done, ovf, mreg, msb, mcnt, (mcnt == 8), movf);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_ashr();
      test_add_sub_ovf();
      test_shr();
      test_saturation();
      test_mid_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
